// File: rtl/wbu_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : wbu_arb_if
// Description : Bus bundle for the writeback arbiter. Carries the EXU and LSU
//               result handshakes, the issue-stage destination allocation,
//               the busy scoreboard and the registered register-file write
//               port. When YSYX_23060251_WBU_PERF_EN is defined it also
//               carries the 64-bit pop/stall performance counters.
//   slave  : arbiter side (results/alloc in, ready/busy/rf/perf out)
//   master : producer/consumer side (the opposite directions)
// Revision    : 1.0 - initial release
// ============================================================================
interface wbu_arb_if #(
  parameter int XLEN = 32,
  parameter int RS_W = 5
);
  logic                 exu_valid_i;
  logic                 exu_ready_o;
  logic                 exu_wen_i;
  logic [RS_W-1:0]      exu_rd_i;
  logic [XLEN-1:0]      exu_data_i;
  logic                 lsu_valid_i;
  logic                 lsu_ready_o;
  logic                 lsu_wen_i;
  logic [RS_W-1:0]      lsu_rd_i;
  logic [XLEN-1:0]      lsu_data_i;
  logic                 alloc_valid_i;
  logic [RS_W-1:0]      alloc_rd_i;
  logic [(1<<RS_W)-1:0] busy_o;
  logic                 rf_wen_o;
  logic [RS_W-1:0]      rf_rd_o;
  logic [XLEN-1:0]      rf_wdata_o;
`ifdef YSYX_23060251_WBU_PERF_EN
  logic [63:0]          perf_exu_cnt_o;
  logic [63:0]          perf_lsu_cnt_o;
  logic [63:0]          perf_stall_cnt_o;
`endif

  modport slave (
    input  exu_valid_i, exu_wen_i, exu_rd_i, exu_data_i,
    input  lsu_valid_i, lsu_wen_i, lsu_rd_i, lsu_data_i,
    input  alloc_valid_i, alloc_rd_i,
`ifdef YSYX_23060251_WBU_PERF_EN
    output perf_exu_cnt_o, perf_lsu_cnt_o, perf_stall_cnt_o,
`endif
    output exu_ready_o, lsu_ready_o, busy_o, rf_wen_o, rf_rd_o, rf_wdata_o
  );

  modport master (
    output exu_valid_i, exu_wen_i, exu_rd_i, exu_data_i,
    output lsu_valid_i, lsu_wen_i, lsu_rd_i, lsu_data_i,
    output alloc_valid_i, alloc_rd_i,
`ifdef YSYX_23060251_WBU_PERF_EN
    input  perf_exu_cnt_o, perf_lsu_cnt_o, perf_stall_cnt_o,
`endif
    input  exu_ready_o, lsu_ready_o, busy_o, rf_wen_o, rf_rd_o, rf_wdata_o
  );
endinterface
`default_nettype wire

// File: rtl/wbu_arb.sv
`default_nettype none
// ============================================================================
// Module      : wbu_arb
// Description : Writeback arbiter. EXU and LSU results are buffered in one
//               2-entry FIFO each; one head is popped per cycle (LSU first,
//               EXU forced after STARVE_MAX consecutive losses) into a
//               registered register-file write port. A per-register busy
//               scoreboard lets the issue stage stall on RAW hazards.
// Ports       : clk_i  - clock, rising edge
//               rst_i  - asynchronous active-low reset
//               bus    - wbu_arb_if.slave (EXU/LSU results, alloc, busy,
//                        rf write port, optional perf counters)
// Option      : YSYX_23060251_WBU_PERF_EN adds 64-bit pop/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module wbu_arb #(
  parameter int XLEN       = 32,
  parameter int RS_W       = 5,
  parameter int STARVE_MAX = 3
) (
  input  wire logic     clk_i,
  input  wire logic     rst_i,
  wbu_arb_if.slave      bus
);
  localparam int NREG = 1 << RS_W;
  localparam int EW   = 1 + RS_W + XLEN;   // entry = {wen, rd, data}
  localparam int SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  // Source index 0 = LSU, 1 = EXU.
  localparam int SRC_LSU = 0;
  localparam int SRC_EXU = 1;

  logic [1:0]    src_valid;
  logic [1:0]    src_ready;
  logic [1:0]    src_ne;
  logic [1:0]    src_pop;
  logic [EW-1:0] src_entry [2];
  logic [EW-1:0] src_head  [2];

  assign src_valid[SRC_LSU] = bus.lsu_valid_i;
  assign src_valid[SRC_EXU] = bus.exu_valid_i;
  assign src_entry[SRC_LSU] = {bus.lsu_wen_i, bus.lsu_rd_i, bus.lsu_data_i};
  assign src_entry[SRC_EXU] = {bus.exu_wen_i, bus.exu_rd_i, bus.exu_data_i};

  // --------------------------------------------------------------------------
  // Per-source 2-entry FIFO. Ready comes from the registered count only, so a
  // full FIFO refuses a push even in a cycle where it is also popped.
  // --------------------------------------------------------------------------
  for (genvar s = 0; s < 2; s++) begin : g_fifo
    logic [1:0]    cnt_q, cnt_d;
    logic          wptr_q, wptr_d;
    logic          rptr_q, rptr_d;
    logic [EW-1:0] mem_q [2];
    logic [EW-1:0] mem_d [2];
    logic          push;

    assign src_ready[s] = ~cnt_q[1];
    assign src_ne[s]    = (cnt_q != 2'd0);
    assign src_head[s]  = mem_q[rptr_q];
    assign push         = src_valid[s] & src_ready[s];

    always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push) begin
        mem_d[wptr_q] = src_entry[s];
        wptr_d        = ~wptr_q;
      end
      if (src_pop[s]) begin
        rptr_d = ~rptr_q;
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, src_pop[s]};
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        cnt_q  <= 2'd0;
        wptr_q <= 1'b0;
        rptr_q <= 1'b0;
        mem_q[0] <= '0;
        mem_q[1] <= '0;
      end else begin
        cnt_q  <= cnt_d;
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        mem_q  <= mem_d;
      end
    end
  end

  assign bus.lsu_ready_o = src_ready[SRC_LSU];
  assign bus.exu_ready_o = src_ready[SRC_EXU];

  // --------------------------------------------------------------------------
  // Arbiter, output register and busy scoreboard
  // --------------------------------------------------------------------------
  logic [SC_W-1:0] starve_q, starve_d;
  logic            rf_wen_q, rf_wen_d;
  logic [RS_W-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic [EW-1:0]   win;
  logic            win_wen;
  logic [RS_W-1:0] win_rd;
  logic [XLEN-1:0] win_data;

  assign win_wen  = win[EW-1];
  assign win_rd   = win[EW-2 -: RS_W];
  assign win_data = win[XLEN-1:0];

  always_comb begin
    src_pop = 2'b00;
    // EXU is forced only once it has lost STARVE_MAX times in a row.
    if (src_ne[SRC_EXU] &&
        (!src_ne[SRC_LSU] || (starve_q == SC_W'(STARVE_MAX)))) begin
      src_pop[SRC_EXU] = 1'b1;
    end else if (src_ne[SRC_LSU]) begin
      src_pop[SRC_LSU] = 1'b1;
    end

    starve_d = (src_ne[SRC_EXU] && src_pop[SRC_LSU]) ? starve_q + SC_W'(1)
                                                     : '0;

    win        = src_pop[SRC_EXU] ? src_head[SRC_EXU] : src_head[SRC_LSU];
    rf_wen_d   = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    if (|src_pop) begin
      // Writes to x0 are popped but never reach the register file.
      rf_wen_d   = win_wen & (win_rd != '0);
      rf_rd_d    = win_rd;
      rf_wdata_d = win_data;
    end

    // Clear on the edge the register file commits; a same-edge alloc wins.
    busy_d = busy_q;
    if (rf_wen_q) begin
      busy_d[rf_rd_q] = 1'b0;
    end
    if (bus.alloc_valid_i && (bus.alloc_rd_i != '0)) begin
      busy_d[bus.alloc_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      starve_q   <= '0;
      rf_wen_q   <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      starve_q   <= starve_d;
      rf_wen_q   <= rf_wen_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.rf_wen_o   = rf_wen_q;
  assign bus.rf_rd_o    = rf_rd_q;
  assign bus.rf_wdata_o = rf_wdata_q;
  assign bus.busy_o     = busy_q;

`ifdef YSYX_23060251_WBU_PERF_EN
  // --------------------------------------------------------------------------
  // Performance counters: pops per source (wen=0 entries included) and cycles
  // in which any source is held off by a full FIFO. All wrap at 2^64.
  // --------------------------------------------------------------------------
  logic [63:0] perf_exu_cnt_q, perf_exu_cnt_d;
  logic [63:0] perf_lsu_cnt_q, perf_lsu_cnt_d;
  logic [63:0] perf_stall_cnt_q, perf_stall_cnt_d;

  always_comb begin
    perf_exu_cnt_d   = perf_exu_cnt_q + {63'd0, src_pop[SRC_EXU]};
    perf_lsu_cnt_d   = perf_lsu_cnt_q + {63'd0, src_pop[SRC_LSU]};
    perf_stall_cnt_d = perf_stall_cnt_q + {63'd0, |(src_valid & ~src_ready)};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perf_exu_cnt_q   <= '0;
      perf_lsu_cnt_q   <= '0;
      perf_stall_cnt_q <= '0;
    end else begin
      perf_exu_cnt_q   <= perf_exu_cnt_d;
      perf_lsu_cnt_q   <= perf_lsu_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end

  assign bus.perf_exu_cnt_o   = perf_exu_cnt_q;
  assign bus.perf_lsu_cnt_o   = perf_lsu_cnt_q;
  assign bus.perf_stall_cnt_o = perf_stall_cnt_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_wbu_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_wbu_arb
// Description : Self-checking bench for wbu_arb. Accepted results are pushed
//               into per-source scoreboard queues; each cycle the expected
//               winner is popped and compared with the registered rf port,
//               together with ready, busy and (when
//               YSYX_23060251_WBU_PERF_EN is defined) the perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wbu_arb;
  typedef struct packed {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wbu_arb_if #(.XLEN(32), .RS_W(5)) bus ();

  wbu_arb #(.XLEN(32), .RS_W(5), .STARVE_MAX(3)) u_dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Scoreboard queues and expected output state
  ent_t        q_exu[$];
  ent_t        q_lsu[$];
  logic        m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [31:0] m_busy;
  int          m_starve;
  logic [7:0]  m_last_src;   // "L", "E" or "-" for the cycle just simulated
`ifdef YSYX_23060251_WBU_PERF_EN
  logic [63:0] m_pe, m_pl, m_ps;
`endif

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_exu.delete();
    q_lsu.delete();
    m_wen = 1'b0; m_rd = '0; m_data = '0; m_busy = '0; m_starve = 0;
    m_last_src = "-";
`ifdef YSYX_23060251_WBU_PERF_EN
    m_pe = '0; m_pl = '0; m_ps = '0;
`endif
  endtask

  task automatic idle();
    bus.exu_valid_i = 1'b0; bus.exu_wen_i = 1'b0; bus.exu_rd_i = '0;
    bus.exu_data_i = '0;
    bus.lsu_valid_i = 1'b0; bus.lsu_wen_i = 1'b0; bus.lsu_rd_i = '0;
    bus.lsu_data_i = '0;
    bus.alloc_valid_i = 1'b0; bus.alloc_rd_i = '0;
  endtask

  task automatic drv_exu(input logic wen, input logic [4:0] rd,
                         input logic [31:0] d);
    bus.exu_valid_i = 1'b1; bus.exu_wen_i = wen; bus.exu_rd_i = rd;
    bus.exu_data_i = d;
  endtask

  task automatic drv_lsu(input logic wen, input logic [4:0] rd,
                         input logic [31:0] d);
    bus.lsu_valid_i = 1'b1; bus.lsu_wen_i = wen; bus.lsu_rd_i = rd;
    bus.lsu_data_i = d;
  endtask

  // One clock: check ready, advance the model over the coming edge, then
  // compare every registered output one step after that edge.
  task automatic cycle();
    logic rdy_e, rdy_l, ne_e, ne_l, pop_e, pop_l;
    logic [31:0] nb;
    ent_t h;
    rdy_e = (q_exu.size() < 2);
    rdy_l = (q_lsu.size() < 2);
    chk("exu_ready", {63'd0, bus.exu_ready_o}, {63'd0, rdy_e});
    chk("lsu_ready", {63'd0, bus.lsu_ready_o}, {63'd0, rdy_l});
    ne_e  = (q_exu.size() > 0);
    ne_l  = (q_lsu.size() > 0);
    pop_e = ne_e && (!ne_l || m_starve == 3);
    pop_l = ne_l && !pop_e;
    nb = m_busy;
    if (m_wen) nb[m_rd] = 1'b0;
    if (bus.alloc_valid_i && bus.alloc_rd_i != 0) nb[bus.alloc_rd_i] = 1'b1;
    nb[0] = 1'b0;
    m_busy = nb;
`ifdef YSYX_23060251_WBU_PERF_EN
    if (pop_e) m_pe++;
    if (pop_l) m_pl++;
    if ((bus.exu_valid_i && !rdy_e) || (bus.lsu_valid_i && !rdy_l)) m_ps++;
`endif
    m_wen = 1'b0;
    m_last_src = "-";
    if (pop_e || pop_l) begin
      h = pop_e ? q_exu.pop_front() : q_lsu.pop_front();
      m_wen  = h.wen && (h.rd != 0);
      m_rd   = h.rd;
      m_data = h.data;
      m_last_src = pop_e ? "E" : "L";
    end
    m_starve = (ne_e && pop_l) ? m_starve + 1 : 0;
    if (bus.exu_valid_i && rdy_e)
      q_exu.push_back({bus.exu_wen_i, bus.exu_rd_i, bus.exu_data_i});
    if (bus.lsu_valid_i && rdy_l)
      q_lsu.push_back({bus.lsu_wen_i, bus.lsu_rd_i, bus.lsu_data_i});
    @(posedge clk);
    #1;
    chk("rf_wen",   {63'd0, bus.rf_wen_o},   {63'd0, m_wen});
    chk("rf_rd",    {59'd0, bus.rf_rd_o},    {59'd0, m_rd});
    chk("rf_wdata", {32'd0, bus.rf_wdata_o}, {32'd0, m_data});
    chk("busy",     {32'd0, bus.busy_o},     {32'd0, m_busy});
`ifdef YSYX_23060251_WBU_PERF_EN
    chk("perf_exu",   bus.perf_exu_cnt_o,   m_pe);
    chk("perf_lsu",   bus.perf_lsu_cnt_o,   m_pl);
    chk("perf_stall", bus.perf_stall_cnt_o, m_ps);
`endif
  endtask

  string bp_pat = "-LLLELLLEL";

  initial begin
    idle();
    model_reset();
    // ---------------- Reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen",   {63'd0, bus.rf_wen_o},   64'd0);
    chk("rst_rd",    {59'd0, bus.rf_rd_o},    64'd0);
    chk("rst_wdata", {32'd0, bus.rf_wdata_o}, 64'd0);
    chk("rst_busy",  {32'd0, bus.busy_o},     64'd0);
    rst_n = 1'b1;

    // ---------------- Single EXU write ----------------
    drv_exu(1'b1, 5'd5, 32'hDEADBEEF);
    cycle();                       // edge 1: accept
    idle();
    cycle();                       // edge 2: writeback visible
    chk("t1_wen",   {63'd0, bus.rf_wen_o},   64'd1);
    chk("t1_rd",    {59'd0, bus.rf_rd_o},    64'd5);
    chk("t1_wdata", {32'd0, bus.rf_wdata_o}, 64'hDEADBEEF);
    cycle();                       // edge 3
    chk("t1_wen_off", {63'd0, bus.rf_wen_o}, 64'd0);

    // ---------------- x0 suppression and wen=0 entry ----------------
    drv_lsu(1'b1, 5'd0, 32'h1234);
    cycle();
    idle();
    cycle();
    chk("x0_wen",   {63'd0, bus.rf_wen_o},   64'd0);
    chk("x0_wdata", {32'd0, bus.rf_wdata_o}, 64'h1234);
    chk("x0_busy0", {63'd0, bus.busy_o[0]},  64'd0);
    drv_exu(1'b0, 5'd6, 32'h5555_0006);
    cycle();
    idle();
    cycle();
    chk("nowen_rd", {59'd0, bus.rf_rd_o}, 64'd6);
    repeat (2) cycle();

    // ---------------- Back-pressure: both sources every cycle ----------------
    for (int i = 0; i < 10; i++) begin
      drv_exu(1'b1, 5'((i % 31) + 1), 32'hE000_0000 + i);
      drv_lsu(1'b1, 5'(((i + 3) % 31) + 1), 32'hA000_0000 + i);
      cycle();
      begin
        logic [7:0] exp_c, obs_c;
        exp_c = bp_pat[i];
        obs_c = !bus.rf_wen_o ? "-" :
                (bus.rf_wdata_o[31:28] == 4'hA) ? "L" : "E";
        chk("bp_winner", {56'd0, obs_c}, {56'd0, exp_c});
      end
    end
    idle();
    repeat (8) cycle();
    chk("bp_drained", {62'd0, bus.exu_ready_o, bus.lsu_ready_o}, 64'd3);

    // ---------------- Scoreboard ----------------
    bus.alloc_valid_i = 1'b1; bus.alloc_rd_i = 5'd7;
    cycle();
    chk("sb_set7", {63'd0, bus.busy_o[7]}, 64'd1);
    idle();
    drv_lsu(1'b1, 5'd7, 32'h0000_7007);
    cycle();
    idle();
    cycle();                       // rf_wen=1 rd=7
    cycle();                       // clearing edge
    chk("sb_clr7", {63'd0, bus.busy_o[7]}, 64'd0);
    bus.alloc_valid_i = 1'b1; bus.alloc_rd_i = 5'd7;
    cycle();
    idle();
    drv_lsu(1'b1, 5'd7, 32'h0000_7107);
    cycle();
    idle();
    cycle();                       // rf_wen=1 rd=7
    bus.alloc_valid_i = 1'b1; bus.alloc_rd_i = 5'd7;
    cycle();                       // same-edge clear and re-alloc
    chk("sb_setwins", {63'd0, bus.busy_o[7]}, 64'd1);
    idle();
    bus.alloc_valid_i = 1'b1; bus.alloc_rd_i = 5'd0;
    cycle();
    chk("sb_x0", {63'd0, bus.busy_o[0]}, 64'd0);
    idle();

    // ---------------- Reset mid-operation ----------------
    drv_exu(1'b1, 5'd11, 32'hE111_0000);
    drv_lsu(1'b1, 5'd12, 32'hA222_0000);
    bus.alloc_valid_i = 1'b1; bus.alloc_rd_i = 5'd3;
    cycle();
    bus.alloc_rd_i = 5'd9;
    bus.exu_data_i = 32'hE111_0001; bus.lsu_data_i = 32'hA222_0001;
    cycle();
    bus.alloc_valid_i = 1'b0;
    bus.exu_data_i = 32'hE111_0002; bus.lsu_data_i = 32'hA222_0002;
    cycle();
    chk("mid_busy39", {62'd0, bus.busy_o[9], bus.busy_o[3]}, 64'd3);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_wen",   {63'd0, bus.rf_wen_o},   64'd0);
    chk("mid_rd",    {59'd0, bus.rf_rd_o},    64'd0);
    chk("mid_wdata", {32'd0, bus.rf_wdata_o}, 64'd0);
    chk("mid_busy",  {32'd0, bus.busy_o},     64'd0);
    chk("mid_ready", {62'd0, bus.exu_ready_o, bus.lsu_ready_o}, 64'd3);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) cycle();            // no stale writebacks

    // ---------------- Pop and stall accounting ----------------
    for (int i = 0; i < 5; i++) begin
      drv_exu(1'b1, 5'd20, 32'hE333_0000 + i);
      drv_lsu(1'b1, 5'd21, 32'hA444_0000 + i);
      cycle();
    end
    idle();
    repeat (3) cycle();
    for (int i = 0; i < 2; i++) begin
      drv_exu(1'b1, 5'd22, 32'hE555_0000 + i);
      cycle();
      idle();
      cycle();
    end
`ifdef YSYX_23060251_WBU_PERF_EN
    chk("perf_exu_tot",   bus.perf_exu_cnt_o,   64'd4);
    chk("perf_lsu_tot",   bus.perf_lsu_cnt_o,   64'd5);
    chk("perf_stall_tot", bus.perf_stall_cnt_o, 64'd3);
`endif
    chk("final_empty", {62'd0, bus.exu_ready_o, bus.lsu_ready_o}, 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
